world_dispatcher: RTL and testbench

Next-generation world scan engine. It walks the world RAM entry by entry, waits a configurable read latency, and skips invalid entries. Each valid cube is dispatched to one of NUM_DRAWERS cube_drawer channels, so several cubes can rasterise concurrently. It sits between the world BRAM and a bank of cube_drawer instances; the frame controller starts one scan per frame and waits for done.

---
 rtl/world_dispatcher.sv | 146 ++++++++++++++
 tb/tb_world_dispatcher.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/world_dispatcher.sv
// rtl/world_dispatcher.sv - world RAM scanner that dispatches valid cubes to cube_drawer channels
//
// Optional feature macro: WORLD_DISPATCH_STATS_EN (cubes_drawn / cubes_skipped counters).
// Ports:
//   clk_in, rst_in                   clock, synchronous active-high reset
//   start, busy, done                scan control: start pulse, scan in progress, completion pulse
//   world_read_addr, world_read      world RAM read port; entry = {valid, x, y, z}
//   drawer_start/busy/done           per-channel cube_drawer handshake
//   x_corner, y_corner, z_corner     per-channel fixed-point corners, channel k at [k*COORD_WIDTH +: COORD_WIDTH]
//   cube_index                       per-channel world index, channel k at [k*WORLD_BITS +: WORLD_BITS]
//   cubes_drawn, cubes_skipped       scan statistics (tied to 0 unless the macro is defined)
module world_dispatcher #(
  parameter int COORD_WIDTH  = 32,
  parameter int WORLD_SIZE   = 100,
  parameter int WORLD_BITS   = 7,
  parameter int READ_LATENCY = 3,
  parameter int NUM_DRAWERS  = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               start,
  input  logic [3*COORD_WIDTH/2:0]           world_read,
  output logic [WORLD_BITS-1:0]              world_read_addr,
  output logic [NUM_DRAWERS-1:0]             drawer_start,
  input  logic [NUM_DRAWERS-1:0]             drawer_busy,
  input  logic [NUM_DRAWERS-1:0]             drawer_done,
  output logic [NUM_DRAWERS*COORD_WIDTH-1:0] x_corner,
  output logic [NUM_DRAWERS*COORD_WIDTH-1:0] y_corner,
  output logic [NUM_DRAWERS*COORD_WIDTH-1:0] z_corner,
  output logic [NUM_DRAWERS*WORLD_BITS-1:0]  cube_index,
  output logic [WORLD_BITS:0]                cubes_drawn,
  output logic [WORLD_BITS:0]                cubes_skipped,
  output logic                               busy,
  output logic                               done
);

  localparam int HALF  = COORD_WIDTH / 2;
  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0]      LAT  = CNT_W'(READ_LATENCY);
  localparam logic [WORLD_BITS-1:0] LAST = WORLD_BITS'(WORLD_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                           state_q, state_d;
  logic [WORLD_BITS-1:0]            index_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [NUM_DRAWERS-1:0]           alloc_q;
  logic [NUM_DRAWERS-1:0]           start_q;
  logic [NUM_DRAWERS-1:0]           grant;
  logic [NUM_DRAWERS*COORD_WIDTH-1:0] x_q, y_q, z_q;
  logic [NUM_DRAWERS*WORLD_BITS-1:0]  idx_q;
  logic                             eval, entry_valid, have_free, dispatch, advance, start_scan;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // Lowest clear bit of alloc_q; zero when every channel is allocated.
    grant       = ~alloc_q & (alloc_q + NUM_DRAWERS'(1));
    have_free   = |grant;
    start_scan  = (state_q == IDLE) && start;
    eval        = (state_q == FETCH) && (cnt_q == LAT);
    entry_valid = world_read[3*HALF];
    dispatch    = eval && entry_valid && have_free;
    // A valid entry with no free channel holds the evaluate cycle (address unchanged).
    advance     = eval && (!entry_valid || have_free);
    state_d     = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (advance && (index_q == LAST)) state_d = DRAIN;
      DRAIN:   if (alloc_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      index_q <= '0;
      cnt_q   <= '0;
      alloc_q <= '0;
      start_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      idx_q   <= '0;
    end else begin
      if (start_scan) begin
        index_q <= '0;
        cnt_q   <= '0;
      end else if (state_q == FETCH) begin
        if (advance) begin
          cnt_q <= '0;
          if (index_q != LAST) index_q <= index_q + WORLD_BITS'(1);
        end else if (!eval) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      for (int k = 0; k < NUM_DRAWERS; k++) begin
        if (start_q[k] && drawer_busy[k]) start_q[k] <= 1'b0;
        // A done that arrives while start is still asserted belongs to no accepted job.
        if (alloc_q[k] && !start_q[k] && drawer_done[k]) alloc_q[k] <= 1'b0;
        if (dispatch && grant[k]) begin
          alloc_q[k] <= 1'b1;
          start_q[k] <= 1'b1;
          x_q[k*COORD_WIDTH +: COORD_WIDTH]  <= {world_read[3*HALF-1 -: HALF], {HALF{1'b0}}};
          y_q[k*COORD_WIDTH +: COORD_WIDTH]  <= {world_read[2*HALF-1 -: HALF], {HALF{1'b0}}};
          z_q[k*COORD_WIDTH +: COORD_WIDTH]  <= {world_read[HALF-1:0], {HALF{1'b0}}};
          idx_q[k*WORLD_BITS +: WORLD_BITS]  <= index_q;
        end
      end
    end
  end

`ifdef WORLD_DISPATCH_STATS_EN
  logic [WORLD_BITS:0] drawn_q, skipped_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || start_scan) begin
      drawn_q   <= '0;
      skipped_q <= '0;
    end else begin
      if (dispatch)             drawn_q   <= drawn_q + (WORLD_BITS+1)'(1);
      if (eval && !entry_valid) skipped_q <= skipped_q + (WORLD_BITS+1)'(1);
    end
  end

  assign cubes_drawn   = drawn_q;
  assign cubes_skipped = skipped_q;
`else
  assign cubes_drawn   = '0;
  assign cubes_skipped = '0;
`endif

  assign world_read_addr = index_q;
  assign drawer_start    = start_q;
  assign x_corner        = x_q;
  assign y_corner        = y_q;
  assign z_corner        = z_q;
  assign cube_index      = idx_q;
  assign busy            = (state_q == FETCH) || (state_q == DRAIN);
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_world_dispatcher.sv
// tb/tb_world_dispatcher.sv - scoreboard bench for world_dispatcher
module tb_world_dispatcher;

  localparam int CW = 32;
  localparam int WS = 8;
  localparam int WB = 3;
  localparam int RL = 3;
  localparam int ND = 2;
`ifdef WORLD_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              start = 1'b0;
  logic [48:0]       world_read;
  logic [WB-1:0]     world_read_addr;
  logic [ND-1:0]     drawer_start, drawer_busy, drawer_done;
  logic [ND*CW-1:0]  x_corner, y_corner, z_corner;
  logic [ND*WB-1:0]  cube_index;
  logic [WB:0]       cubes_drawn, cubes_skipped;
  logic              busy, done;

  world_dispatcher #(.COORD_WIDTH(CW), .WORLD_SIZE(WS), .WORLD_BITS(WB),
                     .READ_LATENCY(RL), .NUM_DRAWERS(ND)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .world_read(world_read),
    .world_read_addr(world_read_addr), .drawer_start(drawer_start),
    .drawer_busy(drawer_busy), .drawer_done(drawer_done),
    .x_corner(x_corner), .y_corner(y_corner), .z_corner(z_corner),
    .cube_index(cube_index), .cubes_drawn(cubes_drawn), .cubes_skipped(cubes_skipped),
    .busy(busy), .done(done)
  );

  initial forever #5 clk_in = ~clk_in;

  // World RAM with a READ_LATENCY-deep read pipeline.
  logic [48:0] mem [WS];
  logic [48:0] pipe [RL];
  initial for (int i = 0; i < RL; i++) pipe[i] = '0;
  always @(posedge clk_in) begin
    pipe[0] <= mem[world_read_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign world_read = pipe[RL-1];

  // Drawer model: accept start after ack_dly cycles, stay busy busy_len cycles, then pulse done.
  bit          model_en = 1'b1;
  int          ack_dly = 0;
  int          busy_len = 50;
  int          phase [ND];
  int          mcnt [ND];
  logic [ND-1:0] mdl_busy = '0, mdl_done = '0, man_busy = '0, man_done = '0;
  assign drawer_busy = model_en ? mdl_busy : man_busy;
  assign drawer_done = model_en ? mdl_done : man_done;

  initial begin
    for (int k = 0; k < ND; k++) begin phase[k] = 0; mcnt[k] = 0; end
    forever begin
      @(posedge clk_in); #1;
      for (int k = 0; k < ND; k++) begin
        mdl_done[k] = 1'b0;
        if (rst_in || !model_en) begin
          phase[k] = 0; mdl_busy[k] = 1'b0;
        end else begin
          case (phase[k])
            0: if (drawer_start[k]) begin
                 if (ack_dly == 0) begin mdl_busy[k] = 1'b1; mcnt[k] = busy_len; phase[k] = 2; end
                 else begin mcnt[k] = ack_dly; phase[k] = 1; end
               end
            1: begin
                 mcnt[k]--;
                 if (mcnt[k] == 0) begin mdl_busy[k] = 1'b1; mcnt[k] = busy_len; phase[k] = 2; end
               end
            default: begin
                 mcnt[k]--;
                 if (mcnt[k] == 0) begin mdl_busy[k] = 1'b0; mdl_done[k] = 1'b1; phase[k] = 0; end
               end
          endcase
        end
      end
    end
  end

  // Scoreboard.
  typedef struct { int ch; logic [31:0] x; logic [31:0] y; logic [31:0] z; int idx; int hold; } disp_t;
  typedef struct { int lat; int drawn; int skipped; } done_t;
  disp_t exp_disp [$];
  done_t exp_done [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_cyc = 0;
  int done_cnt = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_cnt(input int v);
    return STATS ? v : 0;
  endfunction

  logic [ND-1:0] prev_start = '0;
  int hold_cnt [ND];
  int hold_exp [ND];
  disp_t md;
  done_t me;

  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_start = '0;
    end else begin
      for (int k = 0; k < ND; k++) begin
        if (drawer_start[k] && !prev_start[k]) begin
          hold_cnt[k] = 1;
          hold_exp[k] = 1;
          if (exp_disp.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_dispatch: channel %0d index %0d, none expected", k, cube_index[k*WB +: WB]);
          end else begin
            md = exp_disp.pop_front();
            hold_exp[k] = md.hold;
            check("disp_channel", 64'(k), 64'(md.ch));
            check("disp_x_corner", x_corner[k*CW +: CW], md.x);
            check("disp_y_corner", y_corner[k*CW +: CW], md.y);
            check("disp_z_corner", z_corner[k*CW +: CW], md.z);
            check("disp_cube_index", cube_index[k*WB +: WB], 64'(md.idx));
          end
        end else if (drawer_start[k]) begin
          hold_cnt[k]++;
        end else if (prev_start[k]) begin
          check("start_hold_cycles", 64'(hold_cnt[k]), 64'(hold_exp[k]));
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done pulse, none expected (cycle %0d)", cyc);
        end else begin
          me = exp_done.pop_front();
          if (me.lat >= 0) check("done_latency", 64'(cyc - st_cyc), 64'(me.lat));
          check("done_cubes_drawn", cubes_drawn, 64'(me.drawn));
          check("done_cubes_skipped", cubes_skipped, 64'(me.skipped));
          check("done_busy_low", busy, 0);
          check("done_channels_idle", drawer_start | drawer_busy, 0);
        end
      end
      prev_start = drawer_start;
    end
  end

  task automatic pulse_start(input bit record);
    @(posedge clk_in); #1;
    start = 1'b1;
    if (record) st_cyc = cyc;
    @(posedge clk_in); #1;
    start = 1'b0;
  endtask

  task automatic wait_start(input int k, input int budget);
    int n = 0;
    while (!drawer_start[k] && n < budget) begin @(posedge clk_in); #1; n++; end
    check("drawer_start_seen", drawer_start[k], 1);
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin @(posedge clk_in); #1; n++; end
    check("done_seen", 64'(done_cnt - base), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_drawer_start"}, drawer_start, 0);
    check({tag, "_addr"}, world_read_addr, 0);
    check({tag, "_x_corner"}, x_corner, 0);
    check({tag, "_y_corner"}, y_corner, 0);
    check({tag, "_z_corner"}, z_corner, 0);
    check({tag, "_cube_index"}, cube_index, 0);
    check({tag, "_cubes_drawn"}, cubes_drawn, 0);
    check({tag, "_cubes_skipped"}, cubes_skipped, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < WS; i++) mem[i] = '0;
  endtask

  initial begin
    int base;
    clear_mem();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset("reset");
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // All entries invalid: 8 entries x 4 FETCH cycles, one DRAIN cycle, then DONE.
    exp_done.push_back('{lat: 34, drawn: 0, skipped: exp_cnt(8)});
    pulse_start(1'b1);
    wait_done(400);
    repeat (5) @(posedge clk_in);
    #1;
    check("hold_cubes_skipped", cubes_skipped, 64'(exp_cnt(8)));
    check("hold_cubes_drawn", cubes_drawn, 0);

    // Only index 5 valid; drawer acknowledges 2 cycles late so start is held 3 cycles.
    mem[5] = {1'b1, 16'h0002, 16'hFFFF, 16'h0003};
    ack_dly = 2;
    exp_disp.push_back('{ch: 0, x: 32'h00020000, y: 32'hFFFF0000, z: 32'h00030000, idx: 5, hold: 3});
    exp_done.push_back('{lat: -1, drawn: exp_cnt(1), skipped: exp_cnt(7)});
    pulse_start(1'b1);
    wait_done(400);

    // Three valid entries, two channels, 50-cycle drawers: index 2 stalls until channel 0 frees.
    clear_mem();
    mem[0] = {1'b1, 16'h0001, 16'h0001, 16'h0001};
    mem[1] = {1'b1, 16'h0010, 16'h0020, 16'h0030};
    mem[2] = {1'b1, 16'hFFFE, 16'h0007, 16'h0000};
    ack_dly = 0;
    exp_disp.push_back('{ch: 0, x: 32'h00010000, y: 32'h00010000, z: 32'h00010000, idx: 0, hold: 1});
    exp_disp.push_back('{ch: 1, x: 32'h00100000, y: 32'h00200000, z: 32'h00300000, idx: 1, hold: 1});
    exp_disp.push_back('{ch: 0, x: 32'hFFFE0000, y: 32'h00070000, z: 32'h00000000, idx: 2, hold: 1});
    exp_done.push_back('{lat: -1, drawn: exp_cnt(3), skipped: exp_cnt(5)});
    pulse_start(1'b1);
    repeat (28) @(posedge clk_in);
    #1;
    check("stall_addr_held", world_read_addr, 2);
    check("stall_busy", busy, 1);
    check("stall_no_start", drawer_start, 0);
    check("stall_ch0_index", cube_index[0 +: WB], 0);
    check("stall_ch0_x", x_corner[0 +: CW], 32'h00010000);
    check("stall_ch1_index", cube_index[WB +: WB], 1);
    wait_done(400);

    // done together with busy while start is high must not free the channel.
    clear_mem();
    mem[0] = {1'b1, 16'h0005, 16'h0006, 16'h0007};
    model_en = 1'b0;
    exp_disp.push_back('{ch: 0, x: 32'h00050000, y: 32'h00060000, z: 32'h00070000, idx: 0, hold: 1});
    exp_done.push_back('{lat: -1, drawn: exp_cnt(1), skipped: exp_cnt(7)});
    pulse_start(1'b1);
    wait_start(0, 40);
    man_busy[0] = 1'b1;
    man_done[0] = 1'b1;
    @(posedge clk_in); #1;
    man_done[0] = 1'b0;
    base = done_cnt;
    repeat (60) @(posedge clk_in);
    #1;
    check("early_done_ignored_busy", busy, 1);
    check("early_done_no_done", 64'(done_cnt - base), 0);
    check("early_done_x_stable", x_corner[0 +: CW], 32'h00050000);
    check("early_done_z_stable", z_corner[0 +: CW], 32'h00070000);
    man_busy[0] = 1'b0;
    man_done[0] = 1'b1;
    @(posedge clk_in); #1;
    man_done[0] = 1'b0;
    wait_done(40);
    model_en = 1'b1;

    // Reset while drawer_start is held, then a full rescan from index 0.
    ack_dly = 3;
    exp_disp.push_back('{ch: 0, x: 32'h00050000, y: 32'h00060000, z: 32'h00070000, idx: 0, hold: 4});
    pulse_start(1'b1);
    wait_start(0, 40);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    check_reset("midreset");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    ack_dly = 0;
    mem[3] = {1'b1, 16'h0009, 16'h000A, 16'h000B};
    exp_disp.push_back('{ch: 0, x: 32'h00050000, y: 32'h00060000, z: 32'h00070000, idx: 0, hold: 1});
    exp_disp.push_back('{ch: 1, x: 32'h00090000, y: 32'h000A0000, z: 32'h000B0000, idx: 3, hold: 1});
    exp_done.push_back('{lat: -1, drawn: exp_cnt(2), skipped: exp_cnt(6)});
    pulse_start(1'b1);
    wait_done(400);

    // A second start during the scan is ignored: one done, unchanged latency.
    clear_mem();
    exp_done.push_back('{lat: 34, drawn: 0, skipped: exp_cnt(8)});
    pulse_start(1'b1);
    repeat (10) @(posedge clk_in);
    pulse_start(1'b0);
    base = done_cnt;
    wait_done(400);
    repeat (50) @(posedge clk_in);
    #1;
    check("single_done_per_start", 64'(done_cnt - base), 1);
    check("idle_after_done", busy, 0);

    check("disp_queue_empty", 64'(exp_disp.size()), 0);
    check("done_queue_empty", 64'(exp_done.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
